// File: rtl/fixedpoint_pkg.sv
// Shared definitions for the FixedPoint math blocks.
//   sum_t    : (DEF_WIDTH+1)-bit running-sum word used by accumulator/decoder pairs
//   cntw_for : width of a counter that must be able to hold the value 'delay'
package fixedpoint_pkg;
  localparam int DEF_WIDTH = 16;

  typedef logic [DEF_WIDTH:0] sum_t;

  function automatic int cntw_for(input int delay);
    return $clog2(delay + 1);
  endfunction
endpackage

// File: rtl/accuml_diff_if.sv
// Sample stream bundle between an accumulator and its differentiator.
//   clr, add_sub, in_valid, Q : upstream -> decoder
//   out_valid, D_out, primed  : decoder -> downstream
interface accuml_diff_if #(parameter int WIDTH = 16);
  logic           clr;
  logic           add_sub;
  logic           in_valid;
  logic [WIDTH:0] Q;
  logic           out_valid;
  logic [WIDTH:0] D_out;
  logic           primed;

  modport master (output clr, add_sub, in_valid, Q,
                  input  out_valid, D_out, primed);
  modport slave  (input  clr, add_sub, in_valid, Q,
                  output out_valid, D_out, primed);
endinterface

// File: rtl/sample_delay_line.sv
// Enable-gated shift line of DEPTH words, W bits each.
//   clock, reset (async active-low), en (shift), clr (sync flush)
//   d   : new sample written to stage 0
//   tap : stage DEPTH-1, the sample accepted DEPTH shifts ago
module sample_delay_line #(
  parameter int W     = 17,
  parameter int DEPTH = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] tap
);
  logic [DEPTH-1:0][W-1:0] h;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)   h <= '0;
    else if (clr) h <= '0;
    else if (en) begin
      h[0] <= d;
      for (int i = 1; i < DEPTH; i++) h[i] <= h[i-1];
    end
  end

  assign tap = h[DEPTH-1];
endmodule

// File: rtl/accuml_diff.sv
// Differentiator / comb: D = Q[n] - Q[n-DELAY] mod 2^(WIDTH+1), optionally
// negated when the upstream accumulator subtracts. One cycle latency.
//   clock, reset (async active-low)
//   bus.slave : clr, add_sub, in_valid, Q in; out_valid, D_out, primed out
// CNTW must satisfy 2^CNTW > DELAY so the priming counter can reach DELAY.
module accuml_diff
  import fixedpoint_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DELAY = 1,
  parameter int CNTW  = 5
) (
  input  logic          clock,
  input  logic          reset,
  accuml_diff_if.slave  bus
);
  logic [WIDTH:0]  tap, diff, neg;
  logic [CNTW-1:0] cnt;
  logic            accept;

  // clr discards the sample presented in the same cycle
  assign accept = bus.in_valid && !bus.clr;

  sample_delay_line #(.W(WIDTH+1), .DEPTH(DELAY)) u_hist (
    .clock (clock),
    .reset (reset),
    .en    (accept),
    .clr   (bus.clr),
    .d     (bus.Q),
    .tap   (tap)
  );

  // modular arithmetic: wrap across accumulator overflow is intended
  assign diff = bus.Q - tap;
  assign neg  = '0 - diff;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.D_out     <= '0;
      bus.out_valid <= 1'b0;
      bus.primed    <= 1'b0;
      cnt           <= '0;
    end else if (bus.clr) begin
      bus.D_out     <= '0;
      bus.out_valid <= 1'b0;
      bus.primed    <= 1'b0;
      cnt           <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.D_out <= bus.add_sub ? neg : diff;
        if (cnt != CNTW'(DELAY)) cnt <= cnt + 1'b1;
        // rises together with the out_valid of the DELAY-th sample
        if (cnt == CNTW'(DELAY-1)) bus.primed <= 1'b1;
      end
    end
  end
endmodule
